// File: rtl/stream_mac_pkg.sv
// Shared types and widths for the 8-bit multiply-accumulate stream (feeder and accumulator).
package stream_mac_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int RD_AW  = 6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STREAM   = 3'd1,
    GAP      = 3'd2,
    WAIT_RES = 3'd3,
    DONE     = 3'd4
  } feeder_state_t;

  // Address width for a memory of the given depth, never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/feeder_sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read port whose output clears when not enabled.
module feeder_sdp_ram
  import stream_mac_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; a same-cycle write to raddr returns the old word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= {WIDTH{1'b0}};
    end else if (re) begin
      rdata <= mem_r[raddr];
    end else begin
      rdata <= {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/stream_vector_feeder.sv
// Source end of the MAC stream: replays one activation vector against ROWS weight rows
// as gap-controlled bursts and collects the returned dot products for readback.
module stream_vector_feeder
  import stream_mac_pkg::*;
#(
  parameter int LENGTH = 10,
  parameter int ROWS   = 4,
  parameter int GAP    = 0,
  localparam int AW = addr_width(ROWS * LENGTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  input  logic              res_valid,
  input  logic [ACC_W-1:0]  res_data,
  input  logic [RD_AW-1:0]  rd_addr,
  output logic [ACC_W-1:0]  rd_data
);

  localparam int ABW = addr_width(LENGTH);
  localparam int RAW = addr_width(ROWS);
  localparam logic [7:0]  LAST_BEAT   = 8'(LENGTH - 1);
  localparam logic [5:0]  LAST_ROW    = 6'(ROWS - 1);
  localparam logic [15:0] LAST_GAP    = 16'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [6:0]  ROWS_C      = 7'(ROWS);
  localparam logic [AW:0] ACT_DEPTH_C = (AW + 1)'(LENGTH);
  localparam logic [AW:0] WGT_DEPTH_C = (AW + 1)'(ROWS * LENGTH);

  feeder_state_t     state_r;
  logic [7:0]        beat_r;
  logic [5:0]        row_r;
  logic [15:0]       gap_cnt_r;
  logic [6:0]        res_cnt_r;
  logic [AW-1:0]     wgt_addr_r;
  logic              busy_r;
  logic              done_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] act_r [LENGTH];

  logic              issue_s;
  logic [7:0]        issue_beat_s;
  logic [AW-1:0]     issue_addr_s;
  logic              act_we_s;
  logic              wgt_we_s;
  logic              res_we_s;
  logic              rd_ok_s;
  logic [DATA_W-1:0] wgt_q_s;
  logic [ACC_W-1:0]  rd_q_s;

  assign act_we_s = wr_en && !wr_sel && (state_r == IDLE) && ({1'b0, wr_addr} < ACT_DEPTH_C);
  assign wgt_we_s = wr_en && wr_sel && (state_r == IDLE) && ({1'b0, wr_addr} < WGT_DEPTH_C);
  assign res_we_s = res_valid && (res_cnt_r < ROWS_C) &&
                    ((state_r == STREAM) || (state_r == stream_mac_pkg::GAP) || (state_r == WAIT_RES));
  assign rd_ok_s  = ({1'b0, rd_addr} < ROWS_C);

  // Decide the beat that will be on the stream next cycle, so a and b can be registered.
  always_comb begin
    issue_s      = 1'b0;
    issue_beat_s = 8'd0;
    issue_addr_s = wgt_addr_r + AW'(1);
    case (state_r)
      IDLE: begin
        if (start) begin
          issue_s      = 1'b1;
          issue_addr_s = {AW{1'b0}};
        end else begin
          issue_s = 1'b0;
        end
      end
      STREAM: begin
        if (beat_r != LAST_BEAT) begin
          issue_s      = 1'b1;
          issue_beat_s = beat_r + 8'd1;
        end else if ((row_r != LAST_ROW) && (GAP == 0)) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      stream_mac_pkg::GAP: begin
        if (gap_cnt_r == LAST_GAP) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      default: issue_s = 1'b0;
    endcase
  end

  // Activation buffer, loadable only while idle.
  always_ff @(posedge clk) begin
    if (act_we_s) begin
      act_r[wr_addr[ABW-1:0]] <= wr_data;
    end
  end

  // Run sequencing, stream registers and result counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      beat_r      <= 8'd0;
      row_r       <= 6'd0;
      gap_cnt_r   <= 16'd0;
      res_cnt_r   <= 7'd0;
      wgt_addr_r  <= {AW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
      a_r         <= {DATA_W{1'b0}};
    end else begin
      out_valid_r <= issue_s;
      a_r         <= issue_s ? act_r[issue_beat_s[ABW-1:0]] : {DATA_W{1'b0}};
      done_r      <= 1'b0;
      if (issue_s) begin
        beat_r     <= issue_beat_s;
        wgt_addr_r <= issue_addr_s;
      end
      if (res_we_s) begin
        res_cnt_r <= res_cnt_r + 7'd1;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= STREAM;
            busy_r    <= 1'b1;
            row_r     <= 6'd0;
            res_cnt_r <= 7'd0;
          end
        end
        STREAM: begin
          if (beat_r == LAST_BEAT) begin
            if (row_r == LAST_ROW) begin
              state_r <= WAIT_RES;
            end else begin
              row_r <= row_r + 6'd1;
              if (GAP != 0) begin
                state_r   <= stream_mac_pkg::GAP;
                gap_cnt_r <= 16'd0;
              end
            end
          end
        end
        stream_mac_pkg::GAP: begin
          if (gap_cnt_r == LAST_GAP) begin
            state_r <= STREAM;
          end else begin
            gap_cnt_r <= gap_cnt_r + 16'd1;
          end
        end
        WAIT_RES: begin
          // Results may all have arrived while still streaming.
          if ((res_cnt_r == ROWS_C) || (res_we_s && (res_cnt_r == ROWS_C - 7'd1))) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  feeder_sdp_ram #(.WIDTH(DATA_W), .DEPTH(ROWS * LENGTH)) u_wgt_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wgt_we_s),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (issue_s),
    .raddr (issue_addr_s),
    .rdata (wgt_q_s)
  );

  feeder_sdp_ram #(.WIDTH(ACC_W), .DEPTH(ROWS)) u_res_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (res_we_s),
    .waddr (res_cnt_r[RAW-1:0]),
    .wdata (res_data),
    .re    (rd_ok_s),
    .raddr (rd_addr[RAW-1:0]),
    .rdata (rd_q_s)
  );

  assign busy      = busy_r;
  assign done      = done_r;
  assign out_valid = out_valid_r;
  assign a         = a_r;
  assign b         = wgt_q_s;
  assign rd_data   = rd_q_s;

endmodule

// File: tb/tb_stream_vector_feeder.sv
// Directed bench: three feeders (10x4 gap 0, 10x4 gap 3, 1x1) fed by a behavioural accumulator.
module tb_stream_vector_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wr_en, wr_sel, start, start_g, rd_dummy;
  logic [5:0]  wr_addr, rd_addr;
  logic [7:0]  wr_data;
  logic        res_man_en, res_man_v;
  logic [15:0] res_man_d;
  logic        s_wr_en, s_wr_sel, s_start;
  logic [0:0]  s_wr_addr;
  logic [7:0]  s_wr_data;

  logic        busy0, done0, ov0, busy1, done1, ov1, busy2, done2, ov2;
  logic [7:0]  a0, b0, a1, b1, a2, b2;
  logic [15:0] rd0, rd1, rd2;
  logic        rv0;
  logic [15:0] rdat0;

  logic        ov_w [3];
  logic [7:0]  a_w [3];
  logic [7:0]  b_w [3];
  logic [15:0] acc_sum [3];
  logic [15:0] acc_d [3];
  logic        acc_v [3];
  int          acc_beat [3];

  int n_checks = 0;
  int n_fail   = 0;

  assign ov_w[0] = ov0; assign a_w[0] = a0; assign b_w[0] = b0;
  assign ov_w[1] = ov1; assign a_w[1] = a1; assign b_w[1] = b1;
  assign ov_w[2] = ov2; assign a_w[2] = a2; assign b_w[2] = b2;
  assign rv0   = res_man_en ? res_man_v : acc_v[0];
  assign rdat0 = res_man_en ? res_man_d : acc_d[0];

  stream_vector_feeder #(.LENGTH(10), .ROWS(4), .GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy0), .done(done0), .out_valid(ov0),
    .a(a0), .b(b0), .res_valid(rv0), .res_data(rdat0), .rd_addr(rd_addr), .rd_data(rd0)
  );

  stream_vector_feeder #(.LENGTH(10), .ROWS(4), .GAP(3)) dut_g (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start_g), .busy(busy1), .done(done1), .out_valid(ov1),
    .a(a1), .b(b1), .res_valid(acc_v[1]), .res_data(acc_d[1]), .rd_addr(rd_addr), .rd_data(rd1)
  );

  stream_vector_feeder #(.LENGTH(1), .ROWS(1), .GAP(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .wr_sel(s_wr_sel), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .start(s_start), .busy(busy2), .done(done2), .out_valid(ov2),
    .a(a2), .b(b2), .res_valid(acc_v[2]), .res_data(acc_d[2]), .rd_addr(rd_addr), .rd_data(rd2)
  );

  // Accumulator stand-in: wrapping 16-bit sum of a*b per burst, result strobed the cycle after the last beat.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        acc_sum[k] <= 16'd0; acc_d[k] <= 16'd0; acc_v[k] <= 1'b0; acc_beat[k] <= 0;
      end else if (ov_w[k]) begin
        if (acc_beat[k] == ((k == 2) ? 0 : 9)) begin
          acc_v[k]    <= 1'b1;
          acc_d[k]    <= acc_sum[k] + ({8'd0, a_w[k]} * {8'd0, b_w[k]});
          acc_sum[k]  <= 16'd0;
          acc_beat[k] <= 0;
        end else begin
          acc_v[k]    <= 1'b0;
          acc_sum[k]  <= acc_sum[k] + ({8'd0, a_w[k]} * {8'd0, b_w[k]});
          acc_beat[k] <= acc_beat[k] + 1;
        end
      end else begin
        acc_v[k] <= 1'b0;
      end
    end
  end

  task automatic load(input logic sel, input int addr, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 6'(addr); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = 8'd0;
    start = 1'b0; start_g = 1'b0; rd_addr = 6'd0; rd_dummy = 1'b0;
    res_man_en = 1'b0; res_man_v = 1'b0; res_man_d = 16'd0;
    s_wr_en = 1'b0; s_wr_sel = 1'b0; s_wr_addr = 1'b0; s_wr_data = 8'd0; s_start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy0, done0, ov0, a0, b0, rd0} !== 35'd0) begin
      n_fail++; $display("FAIL reset_dut: got %h expected 0", {busy0, done0, ov0, a0, b0, rd0});
    end
    n_checks++;
    if ({busy1, done1, ov1, a1, b1, rd1} !== 35'd0) begin
      n_fail++; $display("FAIL reset_dut_g: got %h expected 0", {busy1, done1, ov1, a1, b1, rd1});
    end
    n_checks++;
    if ({busy2, done2, ov2, a2, b2, rd2} !== 35'd0) begin
      n_fail++; $display("FAIL reset_dut_s: got %h expected 0", {busy2, done2, ov2, a2, b2, rd2});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Tests 1 and 2 together: same data, gap 0 and gap 3 feeders started in the same cycle.
  task automatic test_stream();
    int p, rg, og, dc0, dc1, dcyc0, dcyc1;
    logic [16:0] e0, eg;
    for (int i = 0; i < 10; i++) load(1'b0, i, 8'(i + 1));
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 10; i++) load(1'b1, r * 10 + i, 8'(r + 1));
    dc0 = 0; dc1 = 0; dcyc0 = 0; dcyc1 = 0;
    start = 1'b1; start_g = 1'b1;
    @(negedge clk);
    start = 1'b0; start_g = 1'b0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      p  = cyc - 1;
      e0 = (p < 40) ? {1'b1, 8'(p % 10 + 1), 8'(p / 10 + 1)} : 17'd0;
      rg = p / 13; og = p % 13;
      eg = (rg < 4 && og < 10) ? {1'b1, 8'(og + 1), 8'(rg + 1)} : 17'd0;
      n_checks++;
      if ({ov0, a0, b0} !== e0) begin
        n_fail++; $display("FAIL stream_gap0 cyc %0d: got %h expected %h", cyc, {ov0, a0, b0}, e0);
      end
      n_checks++;
      if ({ov1, a1, b1} !== eg) begin
        n_fail++; $display("FAIL stream_gap3 cyc %0d: got %h expected %h", cyc, {ov1, a1, b1}, eg);
      end
      if (cyc == 1) begin
        n_checks++;
        if ({busy0, busy1} !== 2'b11) begin
          n_fail++; $display("FAIL busy_at_cycle1: got %b expected 11", {busy0, busy1});
        end
      end
      if (done0 === 1'b1) begin dc0++; if (dcyc0 == 0) dcyc0 = cyc; end
      if (done1 === 1'b1) begin dc1++; if (dcyc1 == 0) dcyc1 = cyc; end
      @(negedge clk);
    end
    n_checks++;
    if (dc0 != 1 || dcyc0 != 42) begin
      n_fail++; $display("FAIL done_gap0: got %0d pulses at cyc %0d expected 1 at 42", dc0, dcyc0);
    end
    n_checks++;
    if (dc1 != 1 || dcyc1 != 51) begin
      n_fail++; $display("FAIL done_gap3: got %0d pulses at cyc %0d expected 1 at 51", dc1, dcyc1);
    end
    n_checks++;
    if ({busy0, busy1} !== 2'b00) begin
      n_fail++; $display("FAIL busy_after: got %b expected 00", {busy0, busy1});
    end
    for (int k = 0; k < 4; k++) begin
      rd_addr = 6'(k);
      @(negedge clk);
      n_checks++;
      if (rd0 !== 16'(55 * (k + 1))) begin
        n_fail++; $display("FAIL result_gap0[%0d]: got %0d expected %0d", k, rd0, 55 * (k + 1));
      end
      n_checks++;
      if (rd1 !== 16'(55 * (k + 1))) begin
        n_fail++; $display("FAIL result_gap3[%0d]: got %0d expected %0d", k, rd1, 55 * (k + 1));
      end
    end
  endtask

  task automatic test_reset_abort();
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    n_checks++;
    if ({ov0, a0, b0} !== {1'b1, 8'd6, 8'd2}) begin
      n_fail++; $display("FAIL abort_pre: got %h expected %h", {ov0, a0, b0}, {1'b1, 8'd6, 8'd2});
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy0, ov0, a0, b0} !== 18'd0) begin
      n_fail++; $display("FAIL abort_post: got %h expected 0", {busy0, ov0, a0, b0});
    end
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({busy0, ov0, a0, b0} !== {1'b1, 1'b1, 8'd1, 8'd1}) begin
      n_fail++; $display("FAIL abort_restart: got %h expected %h", {busy0, ov0, a0, b0}, {1'b1, 1'b1, 8'd1, 8'd1});
    end
    n = 0;
    while (done0 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_checks++;
    if (done0 !== 1'b1) begin
      n_fail++; $display("FAIL abort_done_wait: got done=%b expected 1 within 100 cycles", done0);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_load();
    int dc, dcyc, p;
    logic [16:0] e0;
    for (int i = 0; i < 10; i++) load(1'b0, i, 8'd255);
    for (int i = 0; i < 40; i++) load(1'b1, i, 8'd255);
    dc = 0; dcyc = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      p  = cyc - 1;
      e0 = (p < 40) ? {1'b1, 8'd255, 8'd255} : 17'd0;
      n_checks++;
      if ({ov0, a0, b0} !== e0) begin
        n_fail++; $display("FAIL busy_load_stream cyc %0d: got %h expected %h", cyc, {ov0, a0, b0}, e0);
      end
      if (done0 === 1'b1) begin dc++; if (dcyc == 0) dcyc = cyc; end
      wr_en   = (cyc == 3 || cyc == 4);
      wr_sel  = (cyc == 4);
      wr_addr = (cyc == 4) ? 6'd39 : 6'd0;
      wr_data = 8'd0;
      start   = (cyc == 5);
      @(negedge clk);
    end
    wr_en = 1'b0; start = 1'b0;
    n_checks++;
    if (dc != 1 || dcyc != 42) begin
      n_fail++; $display("FAIL busy_load_done: got %0d pulses at cyc %0d expected 1 at 42", dc, dcyc);
    end
    for (int k = 0; k < 4; k++) begin
      rd_addr = 6'(k);
      @(negedge clk);
      n_checks++;
      if (rd0 !== 16'hEC0A) begin
        n_fail++; $display("FAIL wrap_result[%0d]: got %h expected ec0a", k, rd0);
      end
    end
  endtask

  task automatic test_result_limit();
    int dc, dcyc;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; res_man_en = 1'b1; res_man_v = 1'b1; res_man_d = 16'hBEEF; rd_addr = 6'd0;
    @(negedge clk);
    res_man_v = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rd0 !== 16'hEC0A) begin
      n_fail++; $display("FAIL idle_result_ignored: got %h expected ec0a", rd0);
    end
    dc = 0; dcyc = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (done0 === 1'b1) begin dc++; if (dcyc == 0) dcyc = cyc; end
      res_man_v = (cyc >= 2 && cyc <= 7);
      res_man_d = 16'(100 + cyc);
      @(negedge clk);
    end
    res_man_v = 1'b1; res_man_d = 16'hBEEF;
    @(negedge clk);
    res_man_v = 1'b0;
    n_checks++;
    if (dc != 1 || dcyc != 42) begin
      n_fail++; $display("FAIL limit_done: got %0d pulses at cyc %0d expected 1 at 42", dc, dcyc);
    end
    for (int k = 0; k < 4; k++) begin
      rd_addr = 6'(k);
      @(negedge clk);
      n_checks++;
      if (rd0 !== 16'(102 + k)) begin
        n_fail++; $display("FAIL limit_result[%0d]: got %0d expected %0d", k, rd0, 102 + k);
      end
    end
    res_man_en = 1'b0;
  endtask

  task automatic test_single();
    s_wr_en = 1'b1; s_wr_sel = 1'b0; s_wr_addr = 1'b0; s_wr_data = 8'd7;
    @(negedge clk);
    s_wr_sel = 1'b1; s_wr_data = 8'd9;
    @(negedge clk);
    s_wr_en = 1'b0; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n_checks++;
    if ({busy2, ov2, a2, b2} !== {1'b1, 1'b1, 8'd7, 8'd9}) begin
      n_fail++; $display("FAIL single_beat: got %h expected %h", {busy2, ov2, a2, b2}, {1'b1, 1'b1, 8'd7, 8'd9});
    end
    @(negedge clk);
    n_checks++;
    if ({done2, ov2, a2, b2} !== 18'd0) begin
      n_fail++; $display("FAIL single_after_beat: got %h expected 0", {done2, ov2, a2, b2});
    end
    @(negedge clk);
    n_checks++;
    if ({done2, busy2} !== 2'b10) begin
      n_fail++; $display("FAIL single_done: got %b expected 10", {done2, busy2});
    end
    rd_addr = 6'd0;
    @(negedge clk);
    n_checks++;
    if ({done2, rd2} !== {1'b0, 16'd63}) begin
      n_fail++; $display("FAIL single_readback: got done=%b rd=%0d expected done=0 rd=63", done2, rd2);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_reset_abort();
    test_busy_load();
    test_result_limit();
    test_single();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
